serial_ifft_synth: RTL
======================

# serial_ifft_synth

Serial single-bin inverse DFT synthesizer. It is the transmit-side counterpart of `serial_fft_coral`. It accepts one complex bin coefficient per channel, then emits FRAME_LENGTH real time-domain samples per channel, one per accepted output beat. Its `counter` drives the same twiddle table that feeds `serial_fft_coral` (w_re = cos, w_im = −sin, Q1.(W_WIDTH−1)). Each sample is y[n] = re·w_re[n] + im·w_im[n], which is the real part of A·e^{+j2πkn/N}.

## Interface
- W_WIDTH, 16: twiddle width, signed Q1.(W_WIDTH−1).
- S_WIDTH, 32: coefficient width, signed; matches the `serial_fft_coral` output width.
- Y_WIDTH, 16: output sample width, signed.
- SHIFT, W_WIDTH−1: arithmetic right shift applied to the product sum.
- FRAME_LENGTH, 3: samples per frame; must be ≥ 2.
- CHANELS, 2: parallel channels sharing one twiddle stream.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- counter  out  max(1,$clog2(FRAME_LENGTH))  twiddle index n.
- w_re, w_im  in  W_WIDTH each  twiddle for `counter`; the external ROM is combinational and valid in the same cycle.
- valid_i  in  1  coefficient frame valid.
- ready_o  out  1  block can accept a coefficient frame.
- re, im  in  CHANELS×S_WIDTH each  bin coefficients.
- y  out  CHANELS×Y_WIDTH  time-domain samples.
- valid_o  out  1  y valid.
- last_o  out  1  y holds sample n = FRAME_LENGTH−1.
- ready_i  in  1  downstream accepts y.

## Operation
- **FSM states:** IDLE and RUN. ready_o = (state == IDLE), combinational.
- **IDLE:** on valid_i & ready_o, latch re/im into coefficient registers, set counter ← 0 and state ← RUN.
- **Advance condition:** adv = (state == RUN) & (!valid_o | ready_i).
- **On adv:**
  - y[c] ← sat(floor((re_q[c]·w_re + im_q[c]·w_im) >>> SHIFT)).
  - valid_o ← 1.
  - last_o ← (counter == FRAME_LENGTH−1).
  - If counter == FRAME_LENGTH−1: counter ← 0 and state ← IDLE. Otherwise counter ← counter+1.
- **Output consumed with no adv:** when valid_o & ready_i & !adv, valid_o ← 0 and last_o ← 0.
- **Arithmetic:**
  - Each product is S_WIDTH+W_WIDTH bits; the sum is S_WIDTH+W_WIDTH+1 bits. There is no intermediate truncation.
  - The shift is arithmetic, with truncation toward −∞.
  - sat clamps to [−2^(Y_WIDTH−1), 2^(Y_WIDTH−1)−1].
- **Stall:** while the output is stalled (valid_o & !ready_i), y, last_o, counter and the coefficient registers hold. The twiddle inputs are re-read when the stall releases.
- **Coefficient-path isolation:** coefficient registers change only on an accept. re/im inputs are ignored while in RUN.
- **Next frame during pending output:** a new frame may be accepted while the final y is still pending. The output register is untouched until the next adv.
- **Reset:** rstn low at any time, including mid-frame, aborts the frame. On the next edge: state = IDLE, counter = 0, valid_o = 0, last_o = 0, y = 0, coefficient registers = 0. ready_o is therefore 1 after reset.

## Timing
- An accept at edge T puts counter = 0 in cycle T+1; y[0] is registered at edge T+1.
- valid_o is high from cycle T+1 after edge T+1, i.e. one cycle after the accept edge.
- With ready_i held at 1, samples appear on consecutive cycles, and last_o coincides with sample FRAME_LENGTH−1.
- ready_o returns high the cycle after the last adv. Steady-state throughput is FRAME_LENGTH+1 cycles per frame.
- Output is a registered valid/ready stage: the transfer occurs on valid_o & ready_i.

## Structure
- **Package `fft_pkg`:** default widths, and a saturate function parameterised by in/out width.
- **Sub-module `cplx_real_mac`:** one per channel, generated. It computes a·c + b·d, then shifts and saturates, with a registered output under an enable.
- **Top level:** owns the FSM, the counter, the handshake and the coefficient registers.

## Test plan
Configuration for scenarios 1–4: FRAME_LENGTH = 4, W_WIDTH = 16, Y_WIDTH = 16, and the ROM for k = 1 gives (w_re, w_im) = (32767, 0), (0, −32767), (−32767, 0), (0, 32767) for n = 0..3.

1. **Real coefficient:** ready_i = 1, re = 1000, im = 0 → y = 999, 0, −1000, 0 on four consecutive cycles. last_o is high only with −1000's successor, the fourth sample 0.
2. **Imaginary coefficient:** re = 0, im = 1000 → y = 0, −1000, 0, 999.
3. **Saturation:** re = 40000, im = 0 → y = 32767, 0, −32768, 0.
4. **Backpressure:** ready_i is low for 3 cycles after the first sample → y = 999 and counter = 1 are held. The sequence resumes unchanged, and ready_o stays 0 until the frame ends.
5. **Reset mid-frame:** rstn low after sample 1 → the next cycle shows valid_o = 0, counter = 0, ready_o = 1. A new frame afterwards outputs correct values.
6. **Loopback:** random x frames go through `serial_fft_coral` (S_WIDTH = 32), then its re/im feed this block with the same ROM → the output matches a software model of the real part of A·conj(W)·scaling, bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared widths, FSM state type and the saturation helper for the serial
// FFT / IFFT blocks.
package fft_pkg;

    localparam int DEF_W_WIDTH = 16;
    localparam int DEF_S_WIDTH = 32;
    localparam int DEF_Y_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Clamp a sign-extended value into the signed range of an out_w-bit result.
    // The caller keeps the low out_w bits of the return value.
    function automatic logic signed [63:0] sat_s64(input logic signed [63:0] x,
                                                   input int unsigned out_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] res_v;
        max_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 32'd1));
        if (x > max_v) begin
            res_v = max_v;
        end else if (x < min_v) begin
            res_v = min_v;
        end else begin
            res_v = x;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/cplx_real_mac.sv
// One channel of the synthesizer: y = sat((a*c + b*d) >>> SHIFT), held in a
// register that only loads when en is high.
module cplx_real_mac
    import fft_pkg::*;
#(
    parameter int A_W   = DEF_S_WIDTH,
    parameter int B_W   = DEF_W_WIDTH,
    parameter int Y_W   = DEF_Y_WIDTH,
    parameter int SHIFT = DEF_W_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic signed [A_W-1:0] a,
    input  logic signed [A_W-1:0] b,
    input  logic signed [B_W-1:0] c,
    input  logic signed [B_W-1:0] d,
    output logic        [Y_W-1:0] y
);

    localparam int PW = A_W + B_W;
    localparam int SW = PW + 1;

    logic signed [PW-1:0] p0_s;
    logic signed [PW-1:0] p1_s;
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] sh_s;
    logic signed [63:0]   sat_s;
    logic        [Y_W-1:0] y_r;

    // Full-precision products and sum, floor shift, then clamp to the output range.
    always_comb begin
        p0_s  = PW'(a) * PW'(c);
        p1_s  = PW'(b) * PW'(d);
        sum_s = SW'(p0_s) + SW'(p1_s);
        sh_s  = sum_s >>> SHIFT;
        sat_s = sat_s64(64'(sh_s), Y_W);
    end

    // Output register: cleared by reset, loaded on each advance, otherwise held.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            y_r <= '0;
        end else if (en) begin
            y_r <= sat_s[Y_W-1:0];
        end else begin
            y_r <= y_r;
        end
    end

    assign y = y_r;

endmodule

// File: rtl/serial_ifft_synth.sv
// Serial single-bin inverse DFT synthesizer: latches one complex coefficient
// per channel, then streams FRAME_LENGTH real samples per channel through a
// registered valid/ready output stage.
module serial_ifft_synth
    import fft_pkg::*;
#(
    parameter int W_WIDTH      = DEF_W_WIDTH,
    parameter int S_WIDTH      = DEF_S_WIDTH,
    parameter int Y_WIDTH      = DEF_Y_WIDTH,
    parameter int SHIFT        = W_WIDTH - 1,
    parameter int FRAME_LENGTH = 3,
    parameter int CHANELS      = 2,
    localparam int CW          = (FRAME_LENGTH > 2) ? $clog2(FRAME_LENGTH) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    output logic [CW-1:0]                counter,
    input  logic [W_WIDTH-1:0]           w_re,
    input  logic [W_WIDTH-1:0]           w_im,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [CHANELS*S_WIDTH-1:0]   re,
    input  logic [CHANELS*S_WIDTH-1:0]   im,
    output logic [CHANELS*Y_WIDTH-1:0]   y,
    output logic                         valid_o,
    output logic                         last_o,
    input  logic                         ready_i
);

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LENGTH - 1);

    state_e                       state_r;
    state_e                       state_nxt_s;
    logic [CHANELS*S_WIDTH-1:0]   re_q_r;
    logic [CHANELS*S_WIDTH-1:0]   im_q_r;
    logic [CW-1:0]                counter_r;
    logic                         valid_r;
    logic                         last_r;
    logic                         acc_s;
    logic                         adv_s;
    logic                         at_last_s;

    assign ready_o   = (state_r == ST_IDLE);
    assign acc_s     = valid_i & ready_o;
    assign adv_s     = (state_r == ST_RUN) & (!valid_r | ready_i);
    assign at_last_s = (counter_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: start on accept, return to idle after the last sample advances.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (adv_s && at_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Coefficient registers change only on an accepted frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            re_q_r <= '0;
            im_q_r <= '0;
        end else if (acc_s) begin
            re_q_r <= re;
            im_q_r <= im;
        end else begin
            re_q_r <= re_q_r;
            im_q_r <= im_q_r;
        end
    end

    // Twiddle index: restarts on accept, steps on each advance, wraps after the last sample.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            counter_r <= '0;
        end else if (acc_s) begin
            counter_r <= '0;
        end else if (adv_s) begin
            counter_r <= at_last_s ? '0 : counter_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            counter_r <= counter_r;
        end
    end

    // Output handshake: load on advance, drop when consumed without a new sample.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (adv_s) begin
            valid_r <= 1'b1;
            last_r  <= at_last_s;
        end else if (valid_r && ready_i) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= valid_r;
            last_r  <= last_r;
        end
    end

    for (genvar c = 0; c < CHANELS; c++) begin : g_ch
        cplx_real_mac #(
            .A_W   (S_WIDTH),
            .B_W   (W_WIDTH),
            .Y_W   (Y_WIDTH),
            .SHIFT (SHIFT)
        ) u_mac (
            .clk  (clk),
            .rstn (rstn),
            .en   (adv_s),
            .a    (re_q_r[c*S_WIDTH +: S_WIDTH]),
            .b    (im_q_r[c*S_WIDTH +: S_WIDTH]),
            .c    (w_re),
            .d    (w_im),
            .y    (y[c*Y_WIDTH +: Y_WIDTH])
        );
    end

    assign counter = counter_r;
    assign valid_o = valid_r;
    assign last_o  = last_r;

endmodule
